// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: adapts the execute-stage 64-bit data-memory port to a
// 32-bit big-endian external bus. It splits each request into one or two
// bus beats with byte enables and left-justifies read data on dmem_din.
// Optional feature macro: DMEM_TIMEOUT_EN. When it is defined, each beat
// aborts with dmem_error after TIMEOUT_CYCLES cycles without mem_ack.
module dmem_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] dmem_addr,
  input  logic [63:0] dmem_dout,
  input  logic [1:0]  dmem_width,
  input  logic        dmem_rstrobe,
  input  logic        dmem_wstrobe,
  output logic [63:0] dmem_din,
  output logic        dmem_cycle_complete,
  output logic        dmem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t      state;
  logic [1:0]  width_reg;    // latched access width
  logic [1:0]  lane_reg;     // latched addr[1:0], selects read lanes
  logic [31:0] dout_lo_reg;  // low store word, needed for the second 64-bit beat

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`else
  // The parameter only matters when the timeout is built in.
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
`endif

  // Byte enables for one beat: be[3] is the lowest byte address.
  function automatic logic [3:0] lane_be(input logic [1:0] w, input logic [1:0] a);
    logic [3:0] be;
    case (w)
      2'd2:    be = a[1] ? 4'b0011 : 4'b1100;
      2'd3:    be = 4'b1000 >> a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Natural alignment check for the requested width.
  function automatic logic misaligned(input logic [1:0] w, input logic [2:0] a);
    logic m;
    case (w)
      2'd0:    m = (a != 3'b000);
      2'd1:    m = (a[1:0] != 2'b00);
      2'd2:    m = a[0];
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Bus word for the first (or only) store beat; narrow data is replicated.
  function automatic logic [31:0] store_word(input logic [1:0] w, input logic [63:0] d);
    logic [31:0] s;
    case (w)
      2'd0:    s = d[63:32];
      2'd1:    s = d[31:0];
      2'd2:    s = {2{d[15:0]}};
      default: s = {4{d[7:0]}};
    endcase
    return s;
  endfunction

  // Left-justified read result of the first (or only) beat.
  function automatic logic [63:0] read_place(input logic [1:0] w, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [63:0] r;
    logic [7:0]  b;
    case (a)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    case (w)
      2'd2:    r = {(a[1] ? rd[15:0] : rd[31:16]), 48'h0};
      2'd3:    r = {b, 56'h0};
      default: r = {rd, 32'h0};
    endcase
    return r;
  endfunction

  // Request FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      width_reg           <= 2'd0;
      lane_reg            <= 2'd0;
      dout_lo_reg         <= 32'h0;
      dmem_din            <= 64'h0;
      dmem_cycle_complete <= 1'b0;
      dmem_error          <= 1'b0;
      mem_req             <= 1'b0;
      mem_we              <= 1'b0;
      mem_addr            <= 64'h0;
      mem_be              <= 4'h0;
      mem_wdata           <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt            <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          dmem_cycle_complete <= 1'b0;
          dmem_error          <= 1'b0;
          if (dmem_wstrobe || dmem_rstrobe) begin
            width_reg   <= dmem_width;
            lane_reg    <= dmem_addr[1:0];
            dout_lo_reg <= dmem_dout[31:0];
            dmem_din    <= 64'h0;
            if (misaligned(dmem_width, dmem_addr[2:0])) begin
              // Rejected without touching the bus.
              state               <= RESP;
              dmem_cycle_complete <= 1'b1;
              dmem_error          <= 1'b1;
            end else begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_we    <= dmem_wstrobe;
              mem_addr  <= {dmem_addr[63:2], 2'b00};
              mem_be    <= lane_be(dmem_width, dmem_addr[1:0]);
              mem_wdata <= dmem_wstrobe ? store_word(dmem_width, dmem_dout) : 32'h0;
`ifdef DMEM_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end
          end
        end

        BEAT0, BEAT1: begin
          if (mem_ack) begin
            if (!mem_we) begin
              if (state == BEAT1) dmem_din[31:0] <= mem_rdata;
              else                dmem_din       <= read_place(width_reg, lane_reg, mem_rdata);
            end
            if (state == BEAT0 && width_reg == 2'd0) begin
              // Second word of a 64-bit access: same request, next address.
              state     <= BEAT1;
              mem_addr  <= mem_addr + 64'd4;
              mem_wdata <= mem_we ? dout_lo_reg : 32'h0;
`ifdef DMEM_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end else begin
              state               <= RESP;
              mem_req             <= 1'b0;
              mem_we              <= 1'b0;
              mem_be              <= 4'h0;
              mem_wdata           <= 32'h0;
              dmem_cycle_complete <= 1'b1;
              dmem_error          <= 1'b0;
            end
          end
`ifdef DMEM_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            // Bus never answered: abandon the access, any remaining beat included.
            state               <= RESP;
            mem_req             <= 1'b0;
            mem_we              <= 1'b0;
            mem_be              <= 4'h0;
            mem_wdata           <= 32'h0;
            dmem_din            <= 64'h0;
            dmem_cycle_complete <= 1'b1;
            dmem_error          <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        default: begin
          // RESP: the completion pulse lasts exactly one cycle.
          state               <= IDLE;
          dmem_cycle_complete <= 1'b0;
          dmem_error          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: hand-computed vectors, immediate
// assertions at each check point, one summary line at the end.
module tb_dmem_bus_bridge;

`ifdef DMEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] dmem_addr = '0;
  logic [63:0] dmem_dout = '0;
  logic [1:0]  dmem_width = '0;
  logic        dmem_rstrobe = 1'b0;
  logic        dmem_wstrobe = 1'b0;
  logic [63:0] dmem_din;
  logic        dmem_cycle_complete;
  logic        dmem_error;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  dmem_bus_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_addr(dmem_addr), .dmem_dout(dmem_dout), .dmem_width(dmem_width),
    .dmem_rstrobe(dmem_rstrobe), .dmem_wstrobe(dmem_wstrobe),
    .dmem_din(dmem_din), .dmem_cycle_complete(dmem_cycle_complete),
    .dmem_error(dmem_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a strobe for edge N; returns in cycle N+1 with strobes low.
  task automatic issue(input logic we, input logic [63:0] a, input logic [63:0] d,
                       input logic [1:0] w);
    dmem_addr    = a;
    dmem_dout    = d;
    dmem_width   = w;
    dmem_wstrobe = we;
    dmem_rstrobe = ~we;
    tick();
    dmem_wstrobe = 1'b0;
    dmem_rstrobe = 1'b0;
    $display("issue we=%0b addr=%h width=%0d", we, a, w);
  endtask

  initial begin
    logic held;

    // Reset state
    tick();
    chk("rst_req", {63'h0, mem_req}, 64'h0);
    chk("rst_complete", {63'h0, dmem_cycle_complete}, 64'h0);
    chk("rst_din", dmem_din, 64'h0);
    chk("rst_be", {60'h0, mem_be}, 64'h0);
    rst_n = 1'b1;
    tick();

    // 64-bit read, zero wait states
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    issue(1'b0, 64'h1000, 64'h0, 2'd0);
    chk("r64_req_b0", {63'h0, mem_req}, 64'h1);
    chk("r64_we", {63'h0, mem_we}, 64'h0);
    chk("r64_addr_b0", mem_addr, 64'h1000);
    chk("r64_be_b0", {60'h0, mem_be}, 64'hF);
    chk("r64_nocomp_b0", {63'h0, dmem_cycle_complete}, 64'h0);
    tick();
    mem_rdata = 32'h01234567;
    chk("r64_req_b1", {63'h0, mem_req}, 64'h1);
    chk("r64_addr_b1", mem_addr, 64'h1004);
    chk("r64_be_b1", {60'h0, mem_be}, 64'hF);
    chk("r64_nocomp_b1", {63'h0, dmem_cycle_complete}, 64'h0);
    tick();
    mem_ack = 1'b0;
    chk("r64_comp", {63'h0, dmem_cycle_complete}, 64'h1);
    chk("r64_err", {63'h0, dmem_error}, 64'h0);
    chk("r64_din", dmem_din, 64'hDEADBEEF01234567);
    chk("r64_req_off", {63'h0, mem_req}, 64'h0);
    tick();
    chk("r64_pulse_end", {63'h0, dmem_cycle_complete}, 64'h0);
    chk("r64_din_hold", dmem_din, 64'hDEADBEEF01234567);

    // 8-bit write at byte 3 of the word
    issue(1'b1, 64'h2003, 64'hFFFFFF12345678AB, 2'd3);
    chk("w8_req", {63'h0, mem_req}, 64'h1);
    chk("w8_we", {63'h0, mem_we}, 64'h1);
    chk("w8_addr", mem_addr, 64'h2000);
    chk("w8_be", {60'h0, mem_be}, 64'h1);
    chk("w8_wdata", {32'h0, mem_wdata}, 64'hABABABAB);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("w8_comp", {63'h0, dmem_cycle_complete}, 64'h1);
    chk("w8_err", {63'h0, dmem_error}, 64'h0);
    chk("w8_req_off", {63'h0, mem_req}, 64'h0);
    tick();

    // 16-bit read, upper halfword lane, three wait cycles
    tick();
    issue(1'b0, 64'h3002, 64'h0, 2'd2);
    chk("r16_be", {60'h0, mem_be}, 64'h3);
    chk("r16_addr", mem_addr, 64'h3000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r16_wait_req", {63'h0, mem_req}, 64'h1);
      chk("r16_wait_comp", {63'h0, dmem_cycle_complete}, 64'h0);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h1111F00D;
    tick();
    mem_ack = 1'b0;
    chk("r16_comp", {63'h0, dmem_cycle_complete}, 64'h1);
    chk("r16_din", dmem_din, 64'hF00D000000000000);
    tick();

    // 32-bit write, misaligned: no bus activity, error completion at N+1
    tick();
    issue(1'b1, 64'h4002, 64'h0000000055667788, 2'd1);
    chk("mis_req", {63'h0, mem_req}, 64'h0);
    chk("mis_comp", {63'h0, dmem_cycle_complete}, 64'h1);
    chk("mis_err", {63'h0, dmem_error}, 64'h1);
    chk("mis_din", dmem_din, 64'h0);
    tick();
    chk("mis_err_clear", {63'h0, dmem_error}, 64'h0);
    chk("mis_comp_clear", {63'h0, dmem_cycle_complete}, 64'h0);

    // 8-bit read from byte 1, zero wait
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h11223344;
    issue(1'b0, 64'h5001, 64'h0, 2'd3);
    chk("r8_be", {60'h0, mem_be}, 64'h4);
    tick();
    mem_ack = 1'b0;
    chk("r8_comp", {63'h0, dmem_cycle_complete}, 64'h1);
    chk("r8_din", dmem_din, 64'h2200000000000000);
    tick();

    // 16-bit write to the lower halfword lane
    tick();
    mem_ack = 1'b1;
    issue(1'b1, 64'h5006, 64'h000000000000BEEF, 2'd2);
    chk("w16_be", {60'h0, mem_be}, 64'h3);
    chk("w16_wdata", {32'h0, mem_wdata}, 64'hBEEFBEEF);
    tick();
    mem_ack = 1'b0;
    chk("w16_comp", {63'h0, dmem_cycle_complete}, 64'h1);
    tick();

    // 32-bit read with no ack
    tick();
    mem_rdata = 32'hCAFEF00D;
    issue(1'b0, 64'h6000, 64'h0, 2'd1);
`ifdef DMEM_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_req_held", {63'h0, mem_req}, 64'h1);
    end
    tick();
    chk("to_req_drop", {63'h0, mem_req}, 64'h0);
    chk("to_comp", {63'h0, dmem_cycle_complete}, 64'h1);
    chk("to_err", {63'h0, dmem_error}, 64'h1);
    chk("to_din", dmem_din, 64'h0);
    tick();
`else
    held = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (mem_req !== 1'b1 || dmem_cycle_complete !== 1'b0) held = 1'b0;
      tick();
    end
    chk("noto_req_held", {63'h0, held}, 64'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("noto_comp", {63'h0, dmem_cycle_complete}, 64'h1);
    chk("noto_din", dmem_din, 64'hCAFEF00D00000000);
    tick();
`endif

    // 64-bit write, reset asserted during the second beat
    tick();
    mem_ack = 1'b1;
    issue(1'b1, 64'h7000, 64'h0102030405060708, 2'd0);
    chk("w64_wdata_b0", {32'h0, mem_wdata}, 64'h01020304);
    tick();
    mem_ack = 1'b0;
    chk("w64_addr_b1", mem_addr, 64'h7004);
    chk("w64_wdata_b1", {32'h0, mem_wdata}, 64'h05060708);
    chk("w64_req_b1", {63'h0, mem_req}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_drop", {63'h0, mem_req}, 64'h0);
    held = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dmem_cycle_complete !== 1'b0) held = 1'b1;
    end
    rst_n = 1'b1;
    tick();
    if (dmem_cycle_complete !== 1'b0) held = 1'b1;
    chk("arst_no_comp", {63'h0, held}, 64'h0);

    // Normal access after reset
    mem_ack = 1'b1;
    mem_rdata = 32'h89ABCDEF;
    issue(1'b0, 64'h8004, 64'h0, 2'd1);
    chk("post_addr", mem_addr, 64'h8004);
    tick();
    mem_ack = 1'b0;
    chk("post_comp", {63'h0, dmem_cycle_complete}, 64'h1);
    chk("post_din", dmem_din, 64'h89ABCDEF00000000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the execute-stage memory unit, between its 64-bit data-memory port and a 32-bit external data bus.
- Converts each strobed request (64/32/16/8-bit, big-endian, byte-addressed) into one or two external bus beats with byte enables.
- Returns read data left-justified on dmem_din and signals completion with a one-cycle dmem_cycle_complete pulse.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles per beat for mem_ack. Used only when DMEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- dmem_addr  in  64  byte address of request
- dmem_dout  in  64  store data; value in low bits, e.g. [7:0] for an 8-bit store
- dmem_width  in  2  access width: 0=64, 1=32, 2=16, 3=8 bit
- dmem_rstrobe  in  1  one-cycle read request
- dmem_wstrobe  in  1  one-cycle write request
- dmem_din  out  64  read data, left-justified
- dmem_cycle_complete  out  1  one-cycle completion pulse
- dmem_error  out  1  valid with complete; misaligned access or timeout
- mem_req  out  1  bus request, held until acked
- mem_we  out  1  bus write
- mem_addr  out  64  word address; bits [1:0] always 0
- mem_be  out  4  byte enables; be[3] is lane [31:24], the lowest byte address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  beat completes on a rising edge where mem_req && mem_ack

Behaviour:
- Reset: all outputs 0; state IDLE.
- Async reset mid-transfer drops mem_req immediately. No completion pulse is generated.
- States:
  - IDLE
  - BEAT0: first or only beat
  - BEAT1: second beat, 64-bit only
  - RESP: drives the completion pulse
- IDLE, strobe sampled at edge N:
  - Latch addr, width, data and direction.
  - wstrobe has priority if both strobes are high.
  - Aligned access: go to BEAT0; mem_req=1 from cycle N+1.
  - Misaligned access (64-bit: addr[2:0]!=0; 32-bit: addr[1:0]!=0; 16-bit: addr[0]!=0): go to RESP; no bus activity; dmem_error=1, dmem_din=0.
- Strobes outside IDLE are ignored.
- mem_addr = {addr[63:2], 2'b00}. For the second beat of a 64-bit access, mem_addr = base + 4.
- Write beats:
  - 64-bit: beat0 wdata=dout[63:32]; beat1 wdata=dout[31:0]; be=1111 on both beats.
  - 32-bit: wdata=dout[31:0]; be=1111.
  - 16-bit: wdata={dout[15:0], dout[15:0]}; be = addr[1]=0 → 1100, addr[1]=1 → 0011.
  - 8-bit: wdata = dout[7:0] replicated 4×; be one-hot: addr[1:0]=00 → 1000, 01 → 0100, 10 → 0010, 11 → 0001.
- Read beats: be follows the same rules as writes.
  - 64-bit: beat0 rdata → din[63:32]; beat1 rdata → din[31:0].
  - 32-bit: din = {rdata, 32'h0}.
  - 16-bit: selected halfword → din[63:48]; other bits 0.
  - 8-bit: selected byte → din[63:56]; other bits 0.
- Beat sequencing:
  - On an acked edge in BEAT0 of a 64-bit access, go to BEAT1. mem_req stays 1; addr/wdata update on the next cycle.
  - Otherwise, the acked final beat goes to RESP with mem_req=0.
  - mem_ack while mem_req=0 is ignored.
- RESP lasts one cycle:
  - dmem_cycle_complete=1 for exactly that cycle.
  - dmem_error holds the result for that cycle, then clears to 0.
  - dmem_din stays stable until the next accepted strobe.
  - State returns to IDLE.
- Latency, zero wait states: 32/16/8-bit complete pulse at N+2; 64-bit at N+3. Each wait cycle adds 1.
- A new strobe is accepted in IDLE, earliest one cycle after the complete pulse.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - A per-beat counter clears on beat entry.
  - If mem_ack is not seen within TIMEOUT_CYCLES cycles with mem_req high: drop mem_req, go to RESP with dmem_error=1 and dmem_din=0. A 64-bit access skips any remaining beat.
- DMEM_TIMEOUT_EN undefined: no counter; the bridge waits indefinitely for mem_ack.

Test Plan:
- 64-bit read, addr 0x1000, zero wait states, rdata 0xDEADBEEF then 0x01234567 → mem_addr 0x1000 then 0x1004, be=1111; complete at N+3; din=0xDEADBEEF01234567; error=0.
- 8-bit write, addr 0x2003, dout=0xAB → single beat at mem_addr 0x2000; be=0001; wdata=0xABABABAB; mem_we=1; complete at N+2.
- 16-bit read, addr 0x3002, rdata 0x1111F00D, ack after 3 wait cycles → be=0011; din=0xF00D000000000000; complete at N+5.
- 32-bit write, misaligned addr 0x4002 → mem_req never asserts; complete at N+1 with error=1 and din=0.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, 32-bit read, ack never arrives → mem_req drops after 4 cycles; complete with error=1. Without the macro, mem_req stays high for 1000 cycles.
- Reset asserted during BEAT1 of a 64-bit write → mem_req=0 asynchronously; no complete pulse; the next request after reset behaves normally.
